// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller.
//   - 3-bit state encodings (also exported on state_o for debug)
//   - state_e enum built from those encodings; encoding 7 is unused
package cache_ctrl_pkg;

    localparam logic [2:0] EncIdle   = 3'd0;
    localparam logic [2:0] EncLookup = 3'd1;
    localparam logic [2:0] EncWrHit  = 3'd2;
    localparam logic [2:0] EncWrThru = 3'd3;
    localparam logic [2:0] EncRefill = 3'd4;
    localparam logic [2:0] EncEvict  = 3'd5;
    localparam logic [2:0] EncResp   = 3'd6;

    typedef enum logic [2:0] {
        StIdle   = EncIdle,
        StLookup = EncLookup,
        StWrHit  = EncWrHit,
        StWrThru = EncWrThru,
        StRefill = EncRefill,
        StEvict  = EncEvict,
        StResp   = EncResp
    } state_e;

endpackage

// File: rtl/cache_ctrl_beat_cnt.sv
// Beat index and memory-wait timeout counters for the cache controller.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clear           - zero both counters (takes priority)
//   advance         - one burst word transferred: bump word_idx, restart timeout
//   stall           - memory state cycle without mem_ready: bump timeout counter
//   word_idx        - current beat within the line (wraps after LINE_WORDS-1)
//   last_beat       - word_idx is on the final word of the line
//   timed_out       - timeout counter has reached TIMEOUT-1
module cache_ctrl_beat_cnt
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = $clog2(LINE_WORDS),
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             stall,
    output logic [CNT_W-1:0] word_idx,
    output logic             last_beat,
    output logic             timed_out
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(LINE_WORDS - 1);
    localparam logic [TMO_W-1:0] TmoMax  = TMO_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        idx_d = idx_q;
        tmo_d = tmo_q;
        if (clear) begin
            idx_d = '0;
            tmo_d = '0;
        end else if (advance) begin
            // LINE_WORDS is a power of two, so the index wraps to 0 by itself
            idx_d = idx_q + CNT_W'(1);
            tmo_d = '0;
        end else if (stall && (tmo_q != TmoMax)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            tmo_q <= '0;
        end else begin
            idx_q <= idx_d;
            tmo_q <= tmo_d;
        end
    end

    assign word_idx  = idx_q;
    assign last_beat = (idx_q == LastIdx);
    assign timed_out = (tmo_q == TmoMax);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller state machine: sequences tag/data RAM access for CPU reads
// and writes, multi-word line refill (and eviction) over the memory port, and
// reports memory-wait timeouts to the CPU. Drives control strobes only.
// Optional feature macro: CACHE_WRITE_BACK_EN (write-back, write-allocate).
// Default build is write-through, no-allocate; dirty is then ignored.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   run, rw                 - CPU request valid / 1=write (sampled in IDLE)
//   hit, dirty              - tag compare and victim dirty bit (valid in LOOKUP)
//   mem_ready               - memory accepted/returned one word this cycle
//   sel_mem_cpu             - data-RAM write source, 1=memory 0=CPU
//   tag_rd_en, data_rd_en   - RAM read strobes
//   tag_wr_en, data_wr_en   - RAM write strobes
//   mem_rd_req, mem_wr_req  - memory requests, held for the whole burst
//   word_idx                - current beat within the line
//   dirty_set, dirty_clr    - dirty bit maintenance (write-back only)
//   cpu_ready, cpu_err      - completion pulse, qualified by timeout error
//   state_o                 - current state encoding
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = $clog2(LINE_WORDS),
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             rw,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_ready,
    output logic             sel_mem_cpu,
    output logic             tag_rd_en,
    output logic             data_rd_en,
    output logic             tag_wr_en,
    output logic             data_wr_en,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic [CNT_W-1:0] word_idx,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic             cpu_ready,
    output logic             cpu_err,
    output logic [2:0]       state_o
);

`ifdef CACHE_WRITE_BACK_EN
    localparam bit WriteBack = 1'b1;
`else
    localparam bit WriteBack = 1'b0;
`endif

    state_e state_q, state_d;
    logic   rw_q, rw_d;
    logic   err_q, err_d;

    logic   mem_state, abort, cnt_clear, cnt_advance, cnt_stall;
    logic   last_beat, timed_out;

    assign mem_state = (state_q == StWrThru) || (state_q == StRefill) || (state_q == StEvict);
    assign cnt_stall = mem_state && !mem_ready;
    // A beat on the timeout cycle wins over the timeout
    assign abort     = cnt_stall && timed_out;
    assign cnt_advance = mem_ready && ((state_q == StRefill) || (state_q == StEvict));
    // Counters sit at zero outside memory states, so entry always starts fresh
    assign cnt_clear = !mem_state || abort || ((state_q == StWrThru) && mem_ready);

    cache_ctrl_beat_cnt #(
        .LINE_WORDS (LINE_WORDS),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) u_beat_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .advance   (cnt_advance),
        .stall     (cnt_stall),
        .word_idx  (word_idx),
        .last_beat (last_beat),
        .timed_out (timed_out)
    );

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        err_d       = err_q;
        sel_mem_cpu = 1'b0;
        tag_rd_en   = 1'b0;
        data_rd_en  = 1'b0;
        tag_wr_en   = 1'b0;
        data_wr_en  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        cpu_ready   = 1'b0;
        cpu_err     = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    rw_d    = rw;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                tag_rd_en  = 1'b1;
                data_rd_en = 1'b1;
                if (hit) begin
                    state_d = rw_q ? StWrHit : StResp;
                end else if (WriteBack && dirty) begin
                    state_d = StEvict;
                end else if (rw_q && !WriteBack) begin
                    state_d = StWrThru;  // no allocate on write miss
                end else begin
                    state_d = StRefill;
                end
            end
            StWrHit: begin
                data_wr_en = 1'b1;
                dirty_set  = WriteBack;
                state_d    = WriteBack ? StResp : StWrThru;
            end
            StWrThru: begin
                mem_wr_req = 1'b1;
                if (mem_ready) begin
                    state_d = StResp;
                end
            end
            StRefill: begin
                mem_rd_req  = 1'b1;
                sel_mem_cpu = 1'b1;
                if (mem_ready) begin
                    data_wr_en = 1'b1;
                    if (last_beat) begin
                        tag_wr_en = 1'b1;
                        // write-allocate: the CPU word is merged after the fill
                        state_d   = rw_q ? StWrHit : StResp;
                    end
                end
            end
            StEvict: begin
                mem_wr_req = 1'b1;
                data_rd_en = 1'b1;
                if (mem_ready && last_beat) begin
                    dirty_clr = WriteBack;
                    state_d   = StRefill;
                end
            end
            StResp: begin
                cpu_ready = 1'b1;
                cpu_err   = err_q;
                err_d     = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            state_d = StResp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;

endmodule
